// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one quotient bit per cycle through a single
// compare/subtract step, results returned with a one-cycle done pulse.
module div_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one restoring step per cycle, WIDTH cycles
  // DONE  | results valid, done pulse, start ignored
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             bit_q;

  // A set top accumulator bit would mean the shifted value already exceeds any divisor.
  always_comb begin
    t      = {r_acc[WIDTH-1:0], q_sh[WIDTH-1]};
    bit_q  = r_acc[WIDTH] || (t >= {1'b0, d_reg});
    r_step = bit_q ? (t - {1'b0, d_reg}) : t;
    q_step = {q_sh[WIDTH-2:0], bit_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_sh        <= '0;
      d_reg       <= '0;
      r_acc       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              q_sh  <= dividend;
              d_reg <= divisor;
              r_acc <= '0;
              cnt   <= '0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          q_sh  <= q_step;
          r_acc <= r_step;
          cnt   <= cnt + CW'(1);
          // Results are captured from the final step so they are valid with done.
          if (cnt == CNT_LAST) begin
            quotient    <= q_step;
            remainder   <= r_step[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: WIDTH=4 directed/random divisions with latency checks,
// plus a WIDTH=2 instance swept over all operand pairs with start held high.
module tb_div_seq_ctrl;

  localparam int W  = 4;
  localparam int W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [W-1:0]  dividend, divisor, quotient, remainder;
  logic          busy, done, div_by_zero;

  logic          start2;
  logic [W2-1:0] dividend2, divisor2, quotient2, remainder2;
  logic          busy2, done2, div_by_zero2;

  div_seq_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  div_seq_ctrl #(.WIDTH(W2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dividend(dividend2), .divisor(divisor2),
    .busy(busy2), .done(done2), .quotient(quotient2), .remainder(remainder2),
    .div_by_zero(div_by_zero2)
  );

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned dbz;
  } exp_t;

  exp_t sb4[$];
  exp_t sb2[$];
  exp_t e4, e2;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned n, input int unsigned d, input int w);
    exp_t e;
    if (d == 0) begin
      e.q   = (1 << w) - 1;
      e.r   = n;
      e.dbz = 1;
    end else begin
      e.q   = n / d;
      e.r   = n % d;
      e.dbz = 0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb4.size() == 0) check_eq("done4_spurious", 32'(done), 0);
      else begin
        e4 = sb4.pop_front();
        check_eq("q4", 32'(quotient), e4.q);
        check_eq("r4", 32'(remainder), e4.r);
        check_eq("dbz4", 32'(div_by_zero), e4.dbz);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (sb2.size() == 0) check_eq("done2_spurious", 32'(done2), 0);
      else begin
        e2 = sb2.pop_front();
        check_eq("q2", 32'(quotient2), e2.q);
        check_eq("r2", 32'(remainder2), e2.r);
        check_eq("dbz2", 32'(div_by_zero2), e2.dbz);
      end
    end
  end

  task automatic wait_idle();
    int lim = 0;
    while (busy && lim < 50) begin
      @(negedge clk);
      lim++;
    end
    check_eq("idle_before_start", 32'(busy), 0);
  endtask

  task automatic wait_done();
    int lim = 0;
    while (!done && lim < 50) begin
      @(negedge clk);
      lim++;
    end
    check_eq("done_seen", 32'(done), 1);
  endtask

  // Caller is at a negedge; operands are scrambled after acceptance.
  task automatic run_div(input int unsigned n, input int unsigned d);
    exp_t e;
    int   cycles;
    e = model(n, d, W);
    wait_idle();
    start    = 1'b1;
    dividend = 4'(n);
    divisor  = 4'(d);
    sb4.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    check_eq("busy_after_start", 32'(busy), 1);
    cycles = 1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("done_latency", 32'(cycles), (d == 0) ? 1 : W + 1);
    @(negedge clk);
    check_eq("busy_after_done", 32'(busy), 0);
    check_eq("done_one_cycle", 32'(done), 0);
    check_eq("quotient_hold", 32'(quotient), e.q);
    check_eq("remainder_hold", 32'(remainder), e.r);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int guard;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    start2    = 1'b0;
    dividend2 = '0;
    divisor2  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_q", 32'(quotient), 0);
    check_eq("rst_r", 32'(remainder), 0);
    check_eq("rst_dbz", 32'(div_by_zero), 0);
    check_eq("rst_busy2", 32'(busy2), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(13, 3);
    run_div(9, 0);
    run_div(2, 3);
    run_div(15, 1);
    run_div(15, 15);
    run_div(0, 5);
    run_div(7, 0);

    // Second start during CALC must be dropped; a start right after done is taken.
    wait_idle();
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    sb4.push_back(model(13, 3, W));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    check_eq("busy_cycle_after_done", 32'(busy), 0);
    run_div(6, 2);

    // Reset in the third cycle of a division.
    wait_idle();
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    sb4.push_back(model(13, 3, W));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("busy_before_abort", 32'(busy), 1);
    rst_n = 1'b0;
    sb4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_q", 32'(quotient), 0);
    check_eq("abort_r", 32'(remainder), 0);
    check_eq("abort_dbz", 32'(div_by_zero), 0);
    repeat (8) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(done), 0);
    end
    run_div(13, 3);

    for (int i = 0; i < 6; i++) run_div($urandom_range(0, 15), $urandom_range(0, 15));

    // WIDTH=2 sweep with start held high; next pair presented whenever idle.
    k     = 0;
    guard = 0;
    start2 = 1'b1;
    while (k < 16 && guard < 500) begin
      if (!busy2) begin
        dividend2 = 2'(k >> 2);
        divisor2  = 2'(k);
        sb2.push_back(model(k >> 2, k & 3, W2));
        k++;
      end
      @(negedge clk);
      guard++;
    end
    start2 = 1'b0;
    check_eq("sweep_all_issued", 32'(k), 16);
    guard = 0;
    while (sb2.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("sb2_drained", 32'(sb2.size()), 0);
    check_eq("sb4_drained", 32'(sb4.size()), 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
